// File: rtl/alu32_core.sv
// alu32_core: 32-bit, 8-operation integer ALU with a registered result and flags.
// Execute-stage datapath block. The result and flags appear one clock after
// the operands are sampled.
// Optional feature macro: ALU32_CARRY_EN adds a registered CarryOut flag
// (carry out of bit 31 for ADD, no-borrow for SUB, 0 for every other Op).
module alu32_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Op,
    output logic [31:0] R,
    output logic        Zero,
    output logic        Overflow
`ifdef ALU32_CARRY_EN
    ,
    output logic        CarryOut
`endif
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_XOR = 3'b011,
        OP_SUB = 3'b100,
        OP_SRA = 3'b101,
        OP_SLL = 3'b110,
        OP_NOR = 3'b111
    } op_e;

    op_e         op_s;
    logic        sub_s;
    logic [31:0] b_add_s;
    logic [31:0] add_res_s;
    logic [31:0] sra1_s, sra2_s, sra4_s, sra8_s, sra16_s;
    logic [31:0] sll1_s, sll2_s, sll4_s, sll8_s, sll16_s;
    logic [31:0] r_next_s;
    logic        ovf_next_s;
    logic        zero_next_s;

    assign op_s = op_e'(Op);

    // SUB reuses the adder: A + ~B + 1, with the +1 injected as carry-in.
    assign sub_s   = (op_s == OP_SUB);
    assign b_add_s = sub_s ? ~B : B;

`ifdef ALU32_CARRY_EN
    logic carry_s;
    logic carry_next_s;
    assign {carry_s, add_res_s} = {1'b0, A} + {1'b0, b_add_s} + {32'd0, sub_s};
`else
    assign add_res_s = A + b_add_s + {31'd0, sub_s};
`endif

    // Logarithmic arithmetic right shifter, sign-filled, stages 1/2/4/8/16.
    assign sra1_s  = B[0] ? {{1{A[31]}},        A[31:1]}       : A;
    assign sra2_s  = B[1] ? {{2{sra1_s[31]}},   sra1_s[31:2]}  : sra1_s;
    assign sra4_s  = B[2] ? {{4{sra2_s[31]}},   sra2_s[31:4]}  : sra2_s;
    assign sra8_s  = B[3] ? {{8{sra4_s[31]}},   sra4_s[31:8]}  : sra4_s;
    assign sra16_s = B[4] ? {{16{sra8_s[31]}},  sra8_s[31:16]} : sra8_s;

    // Logarithmic left shifter, zero-filled, stages 1/2/4/8/16.
    assign sll1_s  = B[0] ? {A[30:0],       1'b0}  : A;
    assign sll2_s  = B[1] ? {sll1_s[29:0],  2'b00} : sll1_s;
    assign sll4_s  = B[2] ? {sll2_s[27:0],  4'h0}  : sll2_s;
    assign sll8_s  = B[3] ? {sll4_s[23:0],  8'h00} : sll4_s;
    assign sll16_s = B[4] ? {sll8_s[15:0], 16'h0000} : sll8_s;

    // Result mux and flag generation for the selected operation.
    always_comb begin
        r_next_s   = 32'd0;
        ovf_next_s = 1'b0;
`ifdef ALU32_CARRY_EN
        carry_next_s = 1'b0;
`endif
        case (op_s)
            OP_AND: r_next_s = A & B;
            OP_OR:  r_next_s = A | B;
            OP_XOR: r_next_s = A ^ B;
            OP_NOR: r_next_s = ~(A | B);
            OP_SRA: r_next_s = sra16_s;
            OP_SLL: r_next_s = sll16_s;
            OP_ADD, OP_SUB: begin
                r_next_s = add_res_s;
                // Same-sign adder inputs with a differently-signed sum; for SUB
                // the second adder input is ~B, which covers the A/B sign-differ rule.
                ovf_next_s = (A[31] == b_add_s[31]) && (add_res_s[31] != A[31]);
`ifdef ALU32_CARRY_EN
                carry_next_s = carry_s;
`endif
            end
            default: begin
                r_next_s   = 32'd0;
                ovf_next_s = 1'b0;
            end
        endcase
        zero_next_s = ~|r_next_s;
    end

    // Output register: reset forces R=0/Zero=1/flags=0, otherwise load the new result.
    always_ff @(posedge clk) begin
        if (rst) begin
            R        <= 32'd0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
`ifdef ALU32_CARRY_EN
            CarryOut <= 1'b0;
`endif
        end else begin
            R        <= r_next_s;
            Zero     <= zero_next_s;
            Overflow <= ovf_next_s;
`ifdef ALU32_CARRY_EN
            CarryOut <= carry_next_s;
`endif
        end
    end

endmodule

// File: tb/tb_alu32_core.sv
// Self-checking bench for alu32_core: the driver pushes the expected response
// of each cycle into a queue, a monitor pops and compares one cycle later.
module tb_alu32_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] r;
    logic        zero;
    logic        ovf;
`ifdef ALU32_CARRY_EN
    logic        carry;
`endif

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        ov;
        logic        c;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu32_core dut (
        .clk      (clk),
        .rst      (rst),
        .A        (a),
        .B        (b),
        .Op       (op),
        .R        (r),
        .Zero     (zero),
        .Overflow (ovf)
`ifdef ALU32_CARRY_EN
        ,
        .CarryOut (carry)
`endif
    );

    // Reference model: plain wide arithmetic on the operation definitions.
    function automatic exp_t model(input logic rst_v, input logic [31:0] av,
                                   input logic [31:0] bv, input logic [2:0] opv);
        exp_t               e;
        longint             sa;
        longint             sb;
        longint             s;
        logic [63:0]        u;
        logic signed [31:0] as32;
        logic [4:0]         sh;
        e    = '0;
        sa   = longint'($signed(av));
        sb   = longint'($signed(bv));
        as32 = av;
        sh   = bv[4:0];
        if (rst_v) begin
            e.z = 1'b1;
            return e;
        end
        case (opv)
            3'd0: e.r = av & bv;
            3'd1: e.r = av | bv;
            3'd3: e.r = av ^ bv;
            3'd7: e.r = ~(av | bv);
            3'd5: e.r = as32 >>> sh;
            3'd6: e.r = av << sh;
            3'd2: begin
                s    = sa + sb;
                u    = s;
                e.r  = u[31:0];
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                u    = {32'd0, av} + {32'd0, bv};
                e.c  = u[32];
            end
            default: begin
                s    = sa - sb;
                u    = s;
                e.r  = u[31:0];
                e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                e.c  = (av >= bv);
            end
        endcase
        e.z = (e.r == 32'd0);
        return e;
    endfunction

    task automatic step(input logic rst_v, input logic [31:0] av,
                        input logic [31:0] bv, input logic [2:0] opv);
        @(negedge clk);
        rst = rst_v;
        a   = av;
        b   = bv;
        op  = opv;
        exp_q.push_back(model(rst_v, av, bv, opv));
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: one result per cycle, checked just after the capturing edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("R", r, e.r);
            cmp("Zero", {31'd0, zero}, {31'd0, e.z});
            cmp("Overflow", {31'd0, ovf}, {31'd0, e.ov});
`ifdef ALU32_CARRY_EN
            cmp("CarryOut", {31'd0, carry}, {31'd0, e.c});
`endif
        end
    end

    initial begin
        rst = 1'b1;
        a   = 32'd0;
        b   = 32'd0;
        op  = 3'd0;
        // Reset with arbitrary operands.
        step(1'b1, 32'h12345678, 32'h9ABCDEF0, 3'd2);
        step(1'b1, 32'hFFFFFFFF, 32'h00000001, 3'd7);
        // Logic ops on complementary patterns.
        step(1'b0, 32'hAAAAAAAA, 32'h55555555, 3'd0);
        step(1'b0, 32'hAAAAAAAA, 32'h55555555, 3'd7);
        step(1'b0, 32'hAAAAAAAA, 32'h55555555, 3'd3);
        step(1'b0, 32'hAAAAAAAA, 32'h55555555, 3'd1);
        // ADD.
        step(1'b0, 32'h40000000, 32'h40000000, 3'd2);
        step(1'b0, 32'd12, 32'd17, 3'd2);
        step(1'b0, 32'd174, 32'd13, 3'd2);
        step(1'b0, 32'hFFFFFFFF, 32'h00000001, 3'd2);
        step(1'b0, 32'h80000000, 32'h80000000, 3'd2);
        // SUB.
        step(1'b0, 32'h00000020, 32'h80000019, 3'd4);
        step(1'b0, 32'd17, 32'd12, 3'd4);
        step(1'b0, 32'd174, 32'd13, 3'd4);
        step(1'b0, 32'd5, 32'd5, 3'd4);
        step(1'b0, 32'd12, 32'd17, 3'd4);
        // SRA.
        step(1'b0, 32'hF800001F, 32'd5, 3'd5);
        step(1'b0, 32'hAAAAAAAA, 32'd31, 3'd5);
        step(1'b0, 32'hDEADBEEF, 32'hFFFFFFE0, 3'd5);
        step(1'b0, 32'h7FFFFFFF, 32'd16, 3'd5);
        // SLL.
        step(1'b0, 32'hF8000013, 32'd5, 3'd6);
        step(1'b0, 32'h1C7003C7, 32'd7, 3'd6);
        step(1'b0, 32'hCAFEF00D, 32'hFFFFFFE0, 3'd6);
        // Reset mid-stream wins over an op, then normal result resumes.
        step(1'b1, 32'h7FFFFFFF, 32'd1, 3'd2);
        step(1'b0, 32'h7FFFFFFF, 32'd1, 3'd2);
        // Randomized ops, occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 $urandom(), $urandom(), 3'($urandom_range(0, 7)));
        end
        // Drain: let the last result be checked, then confirm nothing is left.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results never checked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
